// File: rtl/gate_selftest_sequencer.sv
// gate_selftest_sequencer
//   Self-test sequencer for one external 2-input combinational gate. Applies the
//   four input vectors {a,b}=00,01,10,11 in order, waits SETTLE_CYCLES after each,
//   samples dut_y against the EXPECTED truth table, records a per-vector fail mask
//   and drives pass/fail board LEDs from the held verdict.
//
//   Ports:
//     clk, rst      clock; asynchronous active-high reset
//     start         run request (ignored while busy)
//     dut_a, dut_b  vector driven into the gate under test
//     dut_y         gate output (combinational from dut_a/dut_b)
//     busy          run in progress
//     done, pass    verdict held; pass valid only while done=1
//     fail_mask     bit i set when vector i mismatched
//     led_pass      on while done & pass
//     led_fail      blinks (BLINK_DIV-cycle half period) while done & !pass
//
//   Build option: define SELFTEST_AUTOSTART_EN to launch one run automatically on
//   the first clk edge after reset release (for boards with no start button).
module gate_selftest_sequencer #(
   parameter logic [3:0]  EXPECTED      = 4'b1110,
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter int unsigned BLINK_DIV     = 12000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic       dut_a,
   output logic       dut_b,
   input  logic       dut_y,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] fail_mask,
   output logic       led_pass,
   output logic       led_fail
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_APPLY  = 3'd1;
   localparam logic [2:0] S_SETTLE = 3'd2;
   localparam logic [2:0] S_SAMPLE = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd4;

   localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [BW-1:0] BLINK_LAST  = BW'(BLINK_DIV - 1);
   localparam logic [7:0]    SETTLE_LOAD = (SETTLE_CYCLES > 0) ? 8'(SETTLE_CYCLES - 1) : 8'd0;

   logic [2:0]    state, state_n;
   logic [1:0]    idx, idx_n;
   logic [7:0]    cnt, cnt_n;
   logic [1:0]    vec_n;
   logic [3:0]    mask_n;
   logic          done_n, pass_n, busy_n;
   logic          blink, blink_n;
   logic [BW-1:0] bcnt, bcnt_n;
   logic          go;

`ifdef SELFTEST_AUTOSTART_EN
   // Set by reset, consumed by the first clock edge afterwards.
   logic auto_pend;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) auto_pend <= 1'b1;
      else     auto_pend <= 1'b0;
   end

   assign go = start | auto_pend;
`else
   assign go = start;
`endif

   always_comb begin
      state_n = state;
      idx_n   = idx;
      cnt_n   = cnt;
      vec_n   = {dut_a, dut_b};
      mask_n  = fail_mask;
      done_n  = done;
      pass_n  = pass;
      blink_n = blink;
      bcnt_n  = '0;
      case (state)
         S_IDLE, S_DONE: begin
            if (state == S_DONE) begin
               if (bcnt == BLINK_LAST) blink_n = ~blink;
               else                    bcnt_n  = bcnt + 1'b1;
            end
            // A launch from DONE overrides the blink update above.
            if (go) begin
               state_n = S_APPLY;
               idx_n   = '0;
               vec_n   = '0;
               mask_n  = '0;
               done_n  = 1'b0;
               pass_n  = 1'b0;
               blink_n = 1'b0;
               bcnt_n  = '0;
            end
         end
         S_APPLY: begin
            if (SETTLE_CYCLES == 0) begin
               state_n = S_SAMPLE;
            end else begin
               state_n = S_SETTLE;
               cnt_n   = SETTLE_LOAD;
            end
         end
         S_SETTLE: begin
            if (cnt == 8'd0) state_n = S_SAMPLE;
            else             cnt_n   = cnt - 8'd1;
         end
         S_SAMPLE: begin
            if (dut_y != EXPECTED[idx]) mask_n[idx] = 1'b1;
            if (idx == 2'd3) begin
               // Terminal vector: go to DONE rather than letting idx wrap.
               state_n = S_DONE;
               vec_n   = '0;
               done_n  = 1'b1;
               pass_n  = (mask_n == 4'b0000);
               blink_n = 1'b1;
            end else begin
               state_n = S_APPLY;
               idx_n   = idx + 2'd1;
               vec_n   = idx + 2'd1;
            end
         end
         default: state_n = S_IDLE;
      endcase
      busy_n = (state_n == S_APPLY) || (state_n == S_SETTLE) || (state_n == S_SAMPLE);
   end

   // LEDs are registered from next-state values so they switch on the same
   // edge as done, giving a full first blink half-period.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         idx       <= '0;
         cnt       <= '0;
         dut_a     <= 1'b0;
         dut_b     <= 1'b0;
         fail_mask <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         blink     <= 1'b0;
         bcnt      <= '0;
         led_pass  <= 1'b0;
         led_fail  <= 1'b0;
      end else begin
         state     <= state_n;
         idx       <= idx_n;
         cnt       <= cnt_n;
         {dut_a, dut_b} <= vec_n;
         fail_mask <= mask_n;
         busy      <= busy_n;
         done      <= done_n;
         pass      <= pass_n;
         blink     <= blink_n;
         bcnt      <= bcnt_n;
         led_pass  <= done_n & pass_n;
         led_fail  <= done_n & ~pass_n & blink_n;
      end
   end

endmodule
